// File: rtl/ct_collector_pkg.sv
// Shared definitions for the ciphertext adder/collector stages: lane geometry,
// default polynomial depth, collector FSM states and the lane reduction helper.
package ct_collector_pkg;

    localparam int unsigned DEPTH_DEFAULT = 100;
    localparam int unsigned LANE_W        = 18;
    localparam int unsigned WORD_W        = 2 * LANE_W;
    localparam int unsigned IDX_W         = 10;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDrain   = 2'd2
    } ct_state_e;

    // Reduce both 18-bit lanes mod 2^q_bits, zero-extended back to 18 bits.
    function automatic logic [WORD_W-1:0] reduce_lanes(input logic [WORD_W-1:0] word,
                                                       input int unsigned       q_bits);
        logic [LANE_W-1:0] mask;
        mask = {LANE_W{1'b1}} >> (LANE_W - q_bits);
        return {word[WORD_W-1:LANE_W] & mask, word[LANE_W-1:0] & mask};
    endfunction

endpackage

// File: rtl/ct_collector_if.sv
// Sum-input and drained-output handshake channels of the ciphertext collector.
interface ct_collector_if;
    import ct_collector_pkg::*;

    logic              sum_valid;
    logic [WORD_W-1:0] sum;
    logic [IDX_W-1:0]  sum_idx;
    logic              sum_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_ready;

    modport master (
        output sum_valid, sum, sum_idx, out_ready,
        input  sum_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  sum_valid, sum, sum_idx, out_ready,
        output sum_ready, out_valid, out_data, out_idx
    );

endinterface

// File: rtl/ct_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle latency).
module ct_ram #(
    parameter int unsigned DEPTH = 100,
    parameter int unsigned WIDTH = 36,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ct_collector.sv
// Collects one polynomial of lane-reduced sum words in any index order, then drains
// them in ascending index order through an output register backed by a skid entry.
module ct_collector
    import ct_collector_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned Q_BITS = LANE_W
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start,
    ct_collector_if.slave  bus,
    output logic           done,
    output logic           err,
    output logic           busy
);

    localparam int unsigned      AW        = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    ct_state_e         state_q;
    logic [DEPTH-1:0]  bitmap_q;
    logic [DEPTH-1:0]  wr_onehot;
    logic [DEPTH-1:0]  bitmap_next;

    logic              wr_en_q;
    logic [AW-1:0]     wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic [IDX_W-1:0]  rd_ptr_q;
    logic              rd_pend_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [WORD_W-1:0] rd_data;

    logic              skid_valid_q;
    logic [WORD_W-1:0] skid_data_q;
    logic [IDX_W-1:0]  skid_idx_q;

    logic              sum_ready_q;
    logic              out_valid_q;
    logic [WORD_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              in_range;
    logic              pop;
    logic [1:0]        occ;
    logic              rd_issue;

    always_comb begin
        accept   = bus.sum_valid && sum_ready_q;
        in_range = bus.sum_idx < DEPTH_IDX;
        pop      = out_valid_q && bus.out_ready;

        wr_onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en_q && wr_addr_q == AW'(i)) begin
                wr_onehot[i] = 1'b1;
            end
        end
        bitmap_next = bitmap_q | wr_onehot;

        // Words held or in flight after this cycle; at most two may be outstanding.
        occ      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(pop);
        rd_issue = (state_q == StDrain) && (rd_ptr_q < DEPTH_IDX) && (occ < 2'd2);
    end

    ct_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W),
        .AW    (AW)
    ) u_ram (
        .clk_in (clk_in),
        .we     (wr_en_q),
        .waddr  (wr_addr_q),
        .wdata  (wr_data_q),
        .re     (rd_issue),
        .raddr  (rd_ptr_q[AW-1:0]),
        .rdata  (rd_data)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            bitmap_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_ptr_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_idx_q   <= '0;
            sum_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wr_en_q   <= accept && in_range;
            wr_addr_q <= bus.sum_idx[AW-1:0];
            wr_data_q <= reduce_lanes(bus.sum, Q_BITS);
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end

            rd_pend_q <= rd_issue;
            rd_idx_q  <= rd_ptr_q;
            if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            // Output register refills from the skid entry first to keep index order.
            if (!out_valid_q || bus.out_ready) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_idx_q    <= skid_idx_q;
                    skid_valid_q <= rd_pend_q;
                    skid_data_q  <= rd_data;
                    skid_idx_q   <= rd_idx_q;
                end else if (rd_pend_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= rd_data;
                    out_idx_q   <= rd_idx_q;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= rd_data;
                skid_idx_q   <= rd_idx_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StCollect;
                        sum_ready_q <= 1'b1;
                        bitmap_q    <= '0;
                        err_q       <= 1'b0;
                        rd_ptr_q    <= '0;
                    end
                end
                StCollect: begin
                    bitmap_q <= bitmap_next;
                    if (&bitmap_next) begin
                        state_q     <= StDrain;
                        sum_ready_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (pop && out_idx_q == LAST_IDX) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    sum_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum_ready = sum_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign done          = done_q;
    assign err           = err_q;
    assign busy          = (state_q != StIdle);

endmodule
